video_sig_gen: RTL and testbench
================================

Name: video_sig_gen

Overview:
- Free-running raster timing generator for the HDMI output path (default 1280x720@60, 74.25 MHz pixel clock).
- Produces pixel coordinates, active-draw, syncs, new-frame strobe and a frame counter.
- Downstream delay-line stages retime the sync and active-draw outputs to match framebuffer/BRAM read latency.
- All outputs are registered and mutually aligned: every output describes the same current pixel.

Parameters:
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, horizontal sync width (pixels)
- H_BP, 220, horizontal back porch (pixels)
- V_ACTIVE, 720, visible lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vertical sync width (lines)
- V_BP, 20, vertical back porch (lines)
- SYNC_POL, 1, sync asserted level (1 = active-high)
- FPS, 60, frame counter modulus

Ports:
- clk_in  input  1  pixel clock
- rst_in  input  1  synchronous active-high reset
- hcount_out  output  11  current pixel x, 0..H_TOTAL-1
- vcount_out  output  10  current line y, 0..V_TOTAL-1
- hs_out  output  1  horizontal sync
- vs_out  output  1  vertical sync
- ad_out  output  1  active draw
- nf_out  output  1  new-frame strobe, one cycle
- fc_out  output  6  frame count, 0..FPS-1
- vp_active_out, vp_x_out[7:0], vp_y_out[7:0]: outputs, present only with GB_VIEWPORT_EN (see Optional Feature)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1650). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 750).
- One clock, clk_in. Reset is synchronous and active-high on rst_in.
- While rst_in is high:
  - hcount = H_TOTAL-1, vcount = V_TOTAL-1
  - ad = 0, nf = 0, fc = 0
  - hs = vs = !SYNC_POL (deasserted)
- First rising edge with rst_in low: outputs describe pixel (0,0), ad = 1.
- hcount increments by 1 every cycle. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps V_TOTAL-1 -> 0 at the same edge hcount wraps.
- ad = 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
- hs = SYNC_POL iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (default 1390..1429).
- vs = SYNC_POL iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (default lines 725..729), for every hcount on those lines.
- nf = 1 for exactly the one cycle where hcount = H_ACTIVE and vcount = V_ACTIVE (start of vertical blank).
- fc increments in the same cycle nf asserts (nf and the new fc value are visible together). Wraps FPS-1 -> 0.
- All outputs are derived from the next-state counters and registered, so there is no combinational path from counter to output. Latency from counter state to output is 0 cycles by construction.
- Reset asserted mid-frame: the next edge forces the reset state regardless of counter position. No nf pulse is generated by the reset.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Out-of-range values are unreachable.

Optional Feature:
- Macro: GB_VIEWPORT_EN.
- Defined:
  - Adds parameters SCALE (default 4), X_OFF (default 320), Y_OFF (default 72).
  - Adds outputs vp_active_out, vp_x_out, vp_y_out, describing the 160x144 Game Boy screen centred in the raster.
  - vp_active = 1 iff X_OFF <= hcount < X_OFF+160*SCALE and Y_OFF <= vcount < Y_OFF+144*SCALE.
  - vp_x = (hcount-X_OFF)/SCALE and vp_y = (vcount-Y_OFF)/SCALE, generated with sub-pixel/sub-line counters (no dividers).
  - vp_x and vp_y are 0 when outside the viewport.
  - All three outputs are aligned with hcount/vcount. Reset values: vp_active = 0, vp_x = 0, vp_y = 0.
- Not defined: these ports and the associated logic do not exist.

Test Plan:
- Hold rst_in 3 cycles, release -> during reset hcount = 1649, vcount = 749, ad = 0, hs = 0, vs = 0. First cycle after release: hcount = 0, vcount = 0, ad = 1.
- Run one line -> ad falls at hcount = 1280. hs = 1 for hcount 1390..1429 only. At hcount 1649 -> next cycle hcount = 0, vcount = 1.
- Run to (1280,720) -> nf = 1 for that single cycle and fc goes 0 -> 1. vs = 1 for vcount 725..729 across full lines. (1649,749) wraps to (0,0).
- Run 60 frames -> fc steps 0..59 then returns to 0 on the 60th nf. Exactly 60 nf pulses observed.
- Assert rst_in at (500,300) for 1 cycle -> reset state next edge, restart at (0,0), fc = 0, no nf pulse.
- With GB_VIEWPORT_EN, at vcount = 72:
  - hcount 319 -> vp_active = 0
  - hcount 320 -> vp_active = 1, vp_x = 0, vp_y = 0
  - hcount 323 -> vp_x = 0
  - hcount 324 -> vp_x = 1
  - hcount 959 -> vp_x = 159
  - hcount 960 -> vp_active = 0
  - At vcount = 647 -> vp_y = 143.

Source files
------------

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator: pixel coordinates, syncs, active draw, frame strobe/counter.
// Optional Game Boy viewport outputs are built when GB_VIEWPORT_EN is defined.
module video_sig_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int SYNC_POL = 1,
  parameter int FPS      = 60
`ifdef GB_VIEWPORT_EN
  ,
  parameter int SCALE    = 4,
  parameter int X_OFF    = 320,
  parameter int Y_OFF    = 72
`endif
) (
  input  logic        clk_in,
  input  logic        rst_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        hs_out,
  output logic        vs_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out
`ifdef GB_VIEWPORT_EN
  ,
  output logic        vp_active_out,
  output logic [7:0]  vp_x_out,
  output logic [7:0]  vp_y_out
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_LO   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_HI   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT   = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_LO   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_HI   = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0]  FC_LAST = 6'(FPS - 1);
  localparam logic        SYNC_ON = (SYNC_POL != 0);

  logic [10:0] r_h;
  logic [9:0]  r_v;
  logic        r_hs;
  logic        r_vs;
  logic        r_ad;
  logic        r_nf;
  logic [5:0]  r_fc;

  logic        w_line_end;
  logic [10:0] w_h_next;
  logic [9:0]  w_v_next;
  logic        w_ad_next;
  logic        w_hs_next;
  logic        w_vs_next;
  logic        w_nf_next;
  logic [5:0]  w_fc_next;

  // Every output is decoded from the next counter values, so the registered
  // outputs describe exactly the pixel the counters hold after the edge.
  assign w_line_end = (r_h == H_LAST);
  assign w_h_next   = w_line_end ? '0 : r_h + 11'd1;
  assign w_v_next   = !w_line_end       ? r_v :
                      (r_v == V_LAST)   ? '0  : r_v + 10'd1;
  assign w_ad_next  = (w_h_next < H_ACT) && (w_v_next < V_ACT);
  assign w_hs_next  = ((w_h_next >= HS_LO) && (w_h_next < HS_HI)) ? SYNC_ON : !SYNC_ON;
  assign w_vs_next  = ((w_v_next >= VS_LO) && (w_v_next < VS_HI)) ? SYNC_ON : !SYNC_ON;
  assign w_nf_next  = (w_h_next == H_ACT) && (w_v_next == V_ACT);
  assign w_fc_next  = !w_nf_next          ? r_fc :
                      (r_fc == FC_LAST)   ? '0   : r_fc + 6'd1;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_h  <= H_LAST;
      r_v  <= V_LAST;
      r_hs <= !SYNC_ON;
      r_vs <= !SYNC_ON;
      r_ad <= 1'b0;
      r_nf <= 1'b0;
      r_fc <= '0;
    end else begin
      r_h  <= w_h_next;
      r_v  <= w_v_next;
      r_hs <= w_hs_next;
      r_vs <= w_vs_next;
      r_ad <= w_ad_next;
      r_nf <= w_nf_next;
      r_fc <= w_fc_next;
    end
  end

  assign hcount_out = r_h;
  assign vcount_out = r_v;
  assign hs_out     = r_hs;
  assign vs_out     = r_vs;
  assign ad_out     = r_ad;
  assign nf_out     = r_nf;
  assign fc_out     = r_fc;

`ifdef GB_VIEWPORT_EN
  localparam logic [10:0] X_LO  = 11'(X_OFF);
  localparam logic [10:0] X_HI  = 11'(X_OFF + 160 * SCALE);
  localparam logic [9:0]  Y_LO  = 10'(Y_OFF);
  localparam logic [9:0]  Y_HI  = 10'(Y_OFF + 144 * SCALE);
  localparam logic [7:0]  SC_M1 = 8'(SCALE - 1);

  logic [7:0] r_xs;
  logic [7:0] r_xc;
  logic [7:0] r_ys;
  logic [7:0] r_yc;
  logic       r_vpa;
  logic [7:0] r_vpx;
  logic [7:0] r_vpy;

  logic       w_h_in;
  logic       w_v_in;
  logic [7:0] w_xs_next;
  logic [7:0] w_xc_next;
  logic [7:0] w_ys_next;
  logic [7:0] w_yc_next;

  assign w_h_in = (w_h_next >= X_LO) && (w_h_next < X_HI);
  assign w_v_in = (w_v_next >= Y_LO) && (w_v_next < Y_HI);

  // Sub-pixel counters restart at the viewport edge and step the coarse
  // coordinate once every SCALE pixels, replacing a divide by SCALE.
  always_comb begin
    w_xs_next = '0;
    w_xc_next = '0;
    if (w_h_in && (w_h_next != X_LO)) begin
      if (r_xs == SC_M1) begin
        w_xs_next = '0;
        w_xc_next = r_xc + 8'd1;
      end else begin
        w_xs_next = r_xs + 8'd1;
        w_xc_next = r_xc;
      end
    end
  end

  // Vertical sub-line counters only move on the line boundary.
  always_comb begin
    w_ys_next = r_ys;
    w_yc_next = r_yc;
    if (w_line_end) begin
      w_ys_next = '0;
      w_yc_next = '0;
      if (w_v_in && (w_v_next != Y_LO)) begin
        if (r_ys == SC_M1) begin
          w_yc_next = r_yc + 8'd1;
        end else begin
          w_ys_next = r_ys + 8'd1;
          w_yc_next = r_yc;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_xs  <= '0;
      r_xc  <= '0;
      r_ys  <= '0;
      r_yc  <= '0;
      r_vpa <= 1'b0;
      r_vpx <= '0;
      r_vpy <= '0;
    end else begin
      r_xs  <= w_xs_next;
      r_xc  <= w_xc_next;
      r_ys  <= w_ys_next;
      r_yc  <= w_yc_next;
      r_vpa <= w_h_in && w_v_in;
      r_vpx <= (w_h_in && w_v_in) ? w_xc_next : '0;
      r_vpy <= (w_h_in && w_v_in) ? w_yc_next : '0;
    end
  end

  assign vp_active_out = r_vpa;
  assign vp_x_out      = r_vpx;
  assign vp_y_out      = r_vpy;
`endif

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench for video_sig_gen: default 720p timing for reset and the first line,
// a reduced raster (inverted sync polarity) for frame-level behaviour, optional viewport.
module tb_video_sig_gen;
  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  logic [10:0] d_h;
  logic [9:0]  d_v;
  logic        d_hs, d_vs, d_ad, d_nf;
  logic [5:0]  d_fc;
  logic [10:0] s_h;
  logic [9:0]  s_v;
  logic        s_hs, s_vs, s_ad, s_nf;
  logic [5:0]  s_fc;
`ifdef GB_VIEWPORT_EN
  logic        rst_v = 1'b1;
  logic        d_vpa, s_vpa, v_vpa;
  logic [7:0]  d_vpx, d_vpy, s_vpx, s_vpy, v_vpx, v_vpy;
  logic [10:0] v_h;
  logic [9:0]  v_v;
  logic        v_hs, v_vs, v_ad, v_nf;
  logic [5:0]  v_fc;
`endif

  video_sig_gen u_def (
    .clk_in(clk), .rst_in(rst_d),
    .hcount_out(d_h), .vcount_out(d_v), .hs_out(d_hs), .vs_out(d_vs),
    .ad_out(d_ad), .nf_out(d_nf), .fc_out(d_fc)
`ifdef GB_VIEWPORT_EN
    , .vp_active_out(d_vpa), .vp_x_out(d_vpx), .vp_y_out(d_vpy)
`endif
  );

  // 25 x 13 raster: hs at h 18..20, vs on lines 9..10, active-low syncs.
  video_sig_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(0), .FPS(60)
  ) u_small (
    .clk_in(clk), .rst_in(rst_s),
    .hcount_out(s_h), .vcount_out(s_v), .hs_out(s_hs), .vs_out(s_vs),
    .ad_out(s_ad), .nf_out(s_nf), .fc_out(s_fc)
`ifdef GB_VIEWPORT_EN
    , .vp_active_out(s_vpa), .vp_x_out(s_vpx), .vp_y_out(s_vpy)
`endif
  );

`ifdef GB_VIEWPORT_EN
  // 332 x 33 raster, viewport at x 3..322, y from line 2, SCALE 2.
  video_sig_gen #(
    .H_ACTIVE(326), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(30), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1), .FPS(60), .SCALE(2), .X_OFF(3), .Y_OFF(2)
  ) u_vp (
    .clk_in(clk), .rst_in(rst_v),
    .hcount_out(v_h), .vcount_out(v_v), .hs_out(v_hs), .vs_out(v_vs),
    .ad_out(v_ad), .nf_out(v_nf), .fc_out(v_fc),
    .vp_active_out(v_vpa), .vp_x_out(v_vpx), .vp_y_out(v_vpy)
  );
`endif

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int eh, ev, npulse, nbad;

    // Reset state, default timing and reduced raster
    repeat (3) tick();
    chk("d_rst_h", d_h, 1649);
    chk("d_rst_v", d_v, 749);
    chk("d_rst_ad", d_ad, 0);
    chk("d_rst_hs", d_hs, 0);
    chk("d_rst_vs", d_vs, 0);
    chk("d_rst_nf", d_nf, 0);
    chk("d_rst_fc", d_fc, 0);
    chk("s_rst_h", s_h, 24);
    chk("s_rst_v", s_v, 12);
    chk("s_rst_hs", s_hs, 1);
    chk("s_rst_vs", s_vs, 1);

    // First line of 720p
    rst_d = 1'b0;
    tick();
    for (int k = 0; k < 1650; k++) begin
      chk("d_h", d_h, k);
      chk("d_v", d_v, 0);
      chk("d_ad", d_ad, (k < 1280) ? 1 : 0);
      chk("d_hs", d_hs, (k >= 1390 && k <= 1429) ? 1 : 0);
      chk("d_vs", d_vs, 0);
      chk("d_nf", d_nf, 0);
      tick();
    end
    chk("d_wrap_h", d_h, 0);
    chk("d_wrap_v", d_v, 1);
    chk("d_wrap_ad", d_ad, 1);
    rst_d = 1'b1;

    // One full reduced frame, nf at (16,8)
    rst_s = 1'b0;
    tick();
    for (int k = 0; k < 325; k++) begin
      eh = k % 25;
      ev = k / 25;
      chk("s_h", s_h, eh);
      chk("s_v", s_v, ev);
      chk("s_ad", s_ad, (eh < 16 && ev < 8) ? 1 : 0);
      chk("s_hs", s_hs, (eh >= 18 && eh <= 20) ? 0 : 1);
      chk("s_vs", s_vs, (ev >= 9 && ev <= 10) ? 0 : 1);
      chk("s_nf", s_nf, (eh == 16 && ev == 8) ? 1 : 0);
      chk("s_fc", s_fc, (k >= 216) ? 1 : 0);
      tick();
    end
    chk("s_fwrap_h", s_h, 0);
    chk("s_fwrap_v", s_v, 0);
    chk("s_fwrap_fc", s_fc, 1);

    // Remaining 59 frames: fc steps through 2..59 then 0
    npulse = 1;
    for (int k = 0; k < 59 * 325; k++) begin
      if (s_nf === 1'b1) begin
        npulse++;
        chk("s_fc_at_nf", s_fc, npulse % 60);
      end
      tick();
    end
    chk("s_nf_count", npulse, 60);
    chk("s_fc_wrapped", s_fc, 0);
    chk("s_f61_h", s_h, 0);
    chk("s_f61_v", s_v, 0);

    // Mid-frame reset at (10,9) after one more nf
    repeat (235) tick();
    chk("s_mid_h", s_h, 10);
    chk("s_mid_v", s_v, 9);
    chk("s_mid_fc", s_fc, 1);
    chk("s_mid_vs", s_vs, 0);
    chk("s_mid_hs", s_hs, 1);
    rst_s = 1'b1;
    tick();
    chk("s_mrst_h", s_h, 24);
    chk("s_mrst_v", s_v, 12);
    chk("s_mrst_fc", s_fc, 0);
    chk("s_mrst_nf", s_nf, 0);
    chk("s_mrst_vs", s_vs, 1);
    rst_s = 1'b0;
    tick();
    chk("s_rel_h", s_h, 0);
    chk("s_rel_v", s_v, 0);
    chk("s_rel_ad", s_ad, 1);
    chk("s_rel_fc", s_fc, 0);
    nbad = 0;
    for (int k = 0; k < 216; k++) begin
      if (s_nf !== 1'b0) nbad++;
      tick();
    end
    chk("s_no_early_nf", nbad, 0);
    chk("s_nf_resume", s_nf, 1);
    chk("s_fc_resume", s_fc, 1);

`ifdef GB_VIEWPORT_EN
    // Viewport edges on line Y_OFF, then vertical scaling
    chk("v_rst_vpa", v_vpa, 0);
    chk("v_rst_vpx", v_vpx, 0);
    chk("v_rst_vpy", v_vpy, 0);
    rst_v = 1'b0;
    tick();
    repeat (666) tick();
    chk("v_pos_h", v_h, 2);
    chk("v_pos_v", v_v, 2);
    chk("v_pre_vpa", v_vpa, 0);
    tick();
    chk("v_x0_vpa", v_vpa, 1);
    chk("v_x0_vpx", v_vpx, 0);
    chk("v_x0_vpy", v_vpy, 0);
    tick();
    chk("v_x1_vpx", v_vpx, 0);
    tick();
    chk("v_x2_vpx", v_vpx, 1);
    repeat (317) tick();
    chk("v_last_h", v_h, 322);
    chk("v_last_vpa", v_vpa, 1);
    chk("v_last_vpx", v_vpx, 159);
    tick();
    chk("v_out_vpa", v_vpa, 0);
    chk("v_out_vpx", v_vpx, 0);
    repeat (6327) tick();
    chk("v_l22_h", v_h, 10);
    chk("v_l22_v", v_v, 22);
    chk("v_l22_vpx", v_vpx, 3);
    chk("v_l22_vpy", v_vpy, 10);
    repeat (332) tick();
    chk("v_l23_vpy", v_vpy, 10);
    repeat (332) tick();
    chk("v_l24_vpy", v_vpy, 11);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
